// File: rtl/svc_ascii_pkg.sv
// svc_ascii_pkg: shared ASCII control-character constants and classifiers
package svc_ascii_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    function automatic logic is_term(input logic [7:0] c);
        return c == ASCII_CR || c == ASCII_LF;
    endfunction

    function automatic logic is_erase(input logic [7:0] c);
        return c == ASCII_BS || c == ASCII_DEL;
    endfunction

endpackage

// File: rtl/uart_line_rx_if.sv
// uart_line_rx_if: received-byte strobe in, assembled line with ready handshake out
interface uart_line_rx_if #(
    parameter int MAX_LEN = 128
);

    localparam int MSG_WIDTH = 8*MAX_LEN;
    localparam int LEN_WIDTH = $clog2(MAX_LEN+1);

    logic                 s_valid;
    logic [7:0]           s_char;
    logic                 m_valid;
    logic [MSG_WIDTH-1:0] m_msg;
    logic [LEN_WIDTH-1:0] m_len;
    logic                 m_overflow;
    logic                 m_ready;

    modport slave (
        input  s_valid, s_char, m_ready,
        output m_valid, m_msg, m_len, m_overflow
    );

    modport master (
        output s_valid, s_char, m_ready,
        input  m_valid, m_msg, m_len, m_overflow
    );

endinterface

// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles UART bytes into CR/LF-terminated lines with erase and overflow tracking
module uart_line_rx
    import svc_ascii_pkg::*;
#(
    parameter int MAX_LEN = 128
) (
    input logic          clk,
    input logic          rst,
    uart_line_rx_if.slave rx
);

    localparam int MSG_WIDTH = 8*MAX_LEN;
    localparam int LEN_WIDTH = $clog2(MAX_LEN+1);

    typedef enum logic {COLLECT, PENDING} state_e;

    state_e               state_q, state_d;
    logic [MSG_WIDTH-1:0] buf_q, buf_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 ovf_q, ovf_d;
    logic                 loss_q, loss_d;

    logic term, erase, ord, empty, full;

    assign term  = is_term(rx.s_char);
    assign erase = is_erase(rx.s_char);
    assign ord   = rx.s_valid && !term && !erase;
    assign empty = len_q == '0;
    assign full  = len_q == LEN_WIDTH'(MAX_LEN);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        loss_d  = loss_q;
        if (state_q == COLLECT) begin
            if (rx.s_valid && erase && !empty) begin
                buf_d = buf_q >> 8;
                len_d = len_q - LEN_WIDTH'(1);
            end else if (rx.s_valid && term && !empty) begin
                state_d = PENDING;
            end else if (ord && full) begin
                ovf_d = 1'b1;
            end else if (ord) begin
                buf_d = (buf_q << 8) | MSG_WIDTH'(rx.s_char);
                len_d = len_q + LEN_WIDTH'(1);
            end
        end else if (rx.m_ready) begin
            // a byte arriving with the handshake seeds the next line
            state_d = COLLECT;
            buf_d   = ord ? MSG_WIDTH'(rx.s_char) : '0;
            len_d   = ord ? LEN_WIDTH'(1) : '0;
            ovf_d   = loss_q;
            loss_d  = 1'b0;
        end else if (rx.s_valid) begin
            loss_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            buf_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            loss_q  <= loss_d;
        end
    end

    assign rx.m_valid    = state_q == PENDING;
    assign rx.m_msg      = buf_q;
    assign rx.m_len      = len_q;
    assign rx.m_overflow = ovf_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: scoreboard bench for uart_line_rx with MAX_LEN=4
module tb_uart_line_rx;

    typedef struct packed {
        logic        ovf;
        logic [2:0]  len;
        logic [31:0] msg;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    line_t exp_q[$];
    line_t obs_q[$];

    always #5 clk = ~clk;

    uart_line_rx_if #(.MAX_LEN(4)) lif();

    uart_line_rx #(.MAX_LEN(4)) dut (
        .clk(clk),
        .rst(rst),
        .rx (lif)
    );

    task automatic tick();
        line_t o;
        @(negedge clk);
        if (lif.m_valid && lif.m_ready) begin
            o.ovf = lif.m_overflow;
            o.len = lif.m_len;
            o.msg = lif.m_msg;
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] c);
        lif.s_valid = 1'b1;
        lif.s_char  = c;
        tick();
        lif.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        checks++; if (lif.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", lif.m_valid); end
        checks++; if (lif.m_len !== 3'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", lif.m_len); end
        checks++; if (lif.m_msg !== 32'h0) begin errors++; $display("FAIL reset_msg: got %h want 0", lif.m_msg); end
        checks++; if (lif.m_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", lif.m_overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        line_t e, o;
        lif.m_ready = 1'b1;
        exp_q.push_back(line_t'{1'b0, 3'd3, 32'h00616263});
        send("a"); send("b"); send("c");
        checks++; if (lif.m_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got m_valid %b want 0", lif.m_valid); end
        send(8'h0D);
        checks++; if (lif.m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got m_valid %b want 1", lif.m_valid); end
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL basic_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL basic_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_edit();
        line_t e, o;
        lif.m_ready = 1'b1;
        exp_q.push_back(line_t'{1'b0, 3'd2, 32'h00006163});
        send(8'h08); send("a"); send("b"); send(8'h7F); send("c"); send(8'h0D); send(8'h0A);
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL edit_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL edit_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL edit_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_overflow();
        line_t e, o;
        lif.m_ready = 1'b1;
        exp_q.push_back(line_t'{1'b0, 3'd4, 32'h61626364});
        send("a"); send("b"); send("c"); send("d"); send(8'h0D);
        exp_q.push_back(line_t'{1'b1, 3'd4, 32'h61626364});
        send("a"); send("b"); send("c"); send("d"); send("e"); send("f"); send(8'h0D);
        exp_q.push_back(line_t'{1'b0, 3'd1, 32'h00000078});
        send("x"); send(8'h0D);
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL ovf_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_pending();
        line_t e, o;
        logic [7:0] junk [3] = '{8'h7A, 8'h7A, 8'h0D};
        lif.m_ready = 1'b0;
        exp_q.push_back(line_t'{1'b0, 3'd2, 32'h00006869});
        send("h"); send("i"); send(8'h0D);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) send(junk[i]); else tick();
            checks++;
            if (lif.m_valid !== 1'b1 || lif.m_len !== 3'd2 || lif.m_msg !== 32'h00006869 || lif.m_overflow !== 1'b0) begin
                errors++;
                $display("FAIL pend_hold[%0d]: got v=%b len=%0d msg=%h ovf=%b want v=1 len=2 msg=00006869 ovf=0", i, lif.m_valid, lif.m_len, lif.m_msg, lif.m_overflow);
            end
        end
        lif.m_ready = 1'b1;
        tick();
        exp_q.push_back(line_t'{1'b1, 3'd1, 32'h00000071});
        send("q"); send(8'h0D);
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL pend_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL pend_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pend_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        line_t e, o;
        lif.m_ready = 1'b0;
        exp_q.push_back(line_t'{1'b0, 3'd2, 32'h00006869});
        send("h"); send("i"); send(8'h0D);
        ticks(2);
        lif.m_ready = 1'b1;
        send("k");
        exp_q.push_back(line_t'{1'b0, 3'd2, 32'h00006B6D});
        send("m"); send(8'h0D);
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        line_t e, o;
        lif.m_ready = 1'b1;
        send("a"); send("b");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (lif.m_len !== 3'd0 || lif.m_msg !== 32'h0) begin errors++; $display("FAIL rstmid_clear: got len=%0d msg=%h want len=0 msg=0", lif.m_len, lif.m_msg); end
        exp_q.push_back(line_t'{1'b0, 3'd1, 32'h00000063});
        send("c"); send(8'h0D);
        ticks(3);
        lif.m_ready = 1'b0;
        send("x"); send(8'h0D);
        checks++; if (lif.m_valid !== 1'b1) begin errors++; $display("FAIL rstpend_setup: got m_valid %b want 1", lif.m_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (lif.m_valid !== 1'b0) begin errors++; $display("FAIL rstpend_drop: got m_valid %b want 0", lif.m_valid); end
        lif.m_ready = 1'b1;
        ticks(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_line: got none want len=%0d msg=%h", e.len, e.msg); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rstmid_line: got len=%0d msg=%h ovf=%b want len=%0d msg=%h ovf=%b", o.len, o.msg, o.ovf, e.len, e.msg, e.ovf); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra: got %0d extra lines want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        lif.s_valid = 1'b0;
        lif.s_char  = 8'h00;
        lif.m_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_edit();
        test_overflow();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
